// File: rtl/fft_reorder_ctrl.sv
// -----------------------------------------------------------------------------
// fft_reorder_ctrl
//
// Sequencer for the complex sample buffer that sits between the FFT and the
// demapper. The buffer has a single write port and a registered read port
// that share one write enable. This block writes one OFDM symbol into the
// buffer in natural order. It then reads the symbol back in bit-reversed
// address order, so the FFT output leaves in natural frequency order.
//
// The block drives all buffer control and both handshakes. Sample data goes
// straight through the buffer, so no data bits pass through this module.
// Filling and draining never overlap because the buffer has only one write
// enable. A symbol therefore takes at least N input cycles plus N+1 output
// cycles.
//
// Parameters:
//   N      symbol length and buffer depth (power of two)
//   LOG2N  address width, must equal log2(N)
//   CP     cyclic-prefix length; has an effect only when CP_STRIP_EN is defined
//
// Ports:
//   clk        clock
//   rst_n      asynchronous reset, active-HIGH despite the name
//   in_valid   upstream sample valid
//   in_ready   a sample is accepted this cycle (high only while filling)
//   out_valid  the buffer read register holds a valid reordered sample
//   out_ready  downstream accepts the current sample
//   out_last   the current output is the final sample of the symbol
//   out_index  natural-order index of the current output sample
//   mem_we     buffer write enable
//   mem_addra  buffer write address
//   mem_addrb  buffer read address
//   sym_done   one-cycle pulse after the last sample is accepted downstream
//
// Optional feature (compile-time macro CP_STRIP_EN):
//   When defined, each symbol starts with CP samples. The block accepts them
//   but does not write them, then writes the next N samples as usual.
//   When undefined, every accepted sample is written and CP has no effect.
// -----------------------------------------------------------------------------
module fft_reorder_ctrl #(
  parameter int N     = 64,
  parameter int LOG2N = 6,
  parameter int CP    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [LOG2N-1:0] out_index,
  output logic             mem_we,
  output logic [LOG2N-1:0] mem_addra,
  output logic [LOG2N-1:0] mem_addrb,
  output logic             sym_done
);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [LOG2N-1:0] WR_LAST = LOG2N'(N - 1);
  localparam logic [LOG2N:0]   RD_LAST = (LOG2N + 1)'(N - 1);

  state_t           state;
  logic [LOG2N-1:0] wr_cnt;
  // rd_cnt has one extra bit so it can hold the value N, which means the
  // whole symbol has been issued.
  logic [LOG2N:0]   rd_cnt;
  logic [LOG2N-1:0] held_addr;

  logic             in_hs;
  logic             cp_phase;
  logic             issue;
  logic             done_hs;
  logic [LOG2N-1:0] rd_addr;

  // Reverses the bit order of an address.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

`ifdef CP_STRIP_EN
  localparam int CP_W = (CP > 1) ? $clog2(CP + 1) : 1;
  logic [CP_W-1:0] cp_cnt;

  // Prefix samples are accepted but not written.
  assign cp_phase = (cp_cnt < CP_W'(CP));
`else
  logic unused_cp;

  assign cp_phase  = 1'b0;
  assign unused_cp = (CP < 0);
`endif

  assign in_ready  = (state == FILL);
  assign in_hs     = in_valid & in_ready;
  assign mem_we    = in_hs & ~cp_phase;
  assign mem_addra = wr_cnt;

  // A new read is issued when samples remain and the output register is
  // either empty or being emptied this cycle.
  assign rd_addr = bitrev(rd_cnt[LOG2N-1:0]);
  assign issue   = (state == DRAIN) & ~rd_cnt[LOG2N] & (~out_valid | out_ready);
  assign done_hs = out_valid & out_ready & out_last;

  // During a stall the held address is read again, so the read register
  // reloads the same word and the output data stays stable.
  assign mem_addrb = issue ? rd_addr : held_addr;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= FILL;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      held_addr <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_index <= '0;
      sym_done  <= 1'b0;
`ifdef CP_STRIP_EN
      cp_cnt    <= '0;
`endif
    end else begin
      sym_done <= 1'b0;
      case (state)
        FILL: begin
`ifdef CP_STRIP_EN
          if (in_hs && cp_phase) begin
            cp_cnt <= cp_cnt + 1'b1;
          end
`endif
          if (mem_we) begin
            // wr_cnt wraps to 0 on the final write.
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == WR_LAST) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (issue) begin
            out_valid <= 1'b1;
            out_index <= rd_addr;
            held_addr <= rd_addr;
            out_last  <= (rd_cnt == RD_LAST);
            rd_cnt    <= rd_cnt + 1'b1;
          end else if (done_hs) begin
            // The last sample has left. The next symbol can start filling
            // on the following cycle.
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            sym_done  <= 1'b1;
            rd_cnt    <= '0;
            state     <= FILL;
`ifdef CP_STRIP_EN
            cp_cnt    <= '0;
`endif
          end
        end

        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_reorder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_reorder_ctrl
//
// Directed bench for fft_reorder_ctrl with N=64. A behavioural buffer model
// (written on mem_we, registered read on mem_addrb) carries sample values.
// Expected output order comes from a hand-written bit-reversal table.
// -----------------------------------------------------------------------------
module tb_fft_reorder_ctrl;

  localparam int N     = 64;
  localparam int LOG2N = 6;
  localparam int CP    = 16;
`ifdef CP_STRIP_EN
  localparam int CPL   = CP;
`else
  localparam int CPL   = 0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [LOG2N-1:0] out_index;
  logic             mem_we;
  logic [LOG2N-1:0] mem_addra;
  logic [LOG2N-1:0] mem_addrb;
  logic             sym_done;

  int in_data;
  int mem [N];
  int rdata;

  int n_chk = 0;
  int n_err = 0;

  // Bit-reversed 6-bit indices, written out by hand.
  int br_tab [64] = '{
     0, 32, 16, 48,  8, 40, 24, 56,  4, 36, 20, 52, 12, 44, 28, 60,
     2, 34, 18, 50, 10, 42, 26, 58,  6, 38, 22, 54, 14, 46, 30, 62,
     1, 33, 17, 49,  9, 41, 25, 57,  5, 37, 21, 53, 13, 45, 29, 61,
     3, 35, 19, 51, 11, 43, 27, 59,  7, 39, 23, 55, 15, 47, 31, 63
  };

  fft_reorder_ctrl #(.N(N), .LOG2N(LOG2N), .CP(CP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_index (out_index),
    .mem_we    (mem_we),
    .mem_addra (mem_addra),
    .mem_addrb (mem_addrb),
    .sym_done  (sym_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample buffer: write port plus registered read port.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addra] <= in_data;
    rdata <= mem[mem_addrb];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sends CPL + N samples (base, base+1, ...). If toggle is set, in_valid
  // goes high only on alternate cycles. If expect_done is set, the
  // previous symbol's sym_done pulse is checked on the first cycle.
  task automatic fill_sym(input int base, input bit toggle, input bit expect_done);
    int  sent = 0;
    int  cyc  = 0;
    int  bad  = 0;
    bit  iv;
    while (sent < CPL + N && cyc < 1000) begin
      @(negedge clk);
      iv        = toggle ? (cyc % 2 == 0) : 1'b1;
      in_valid  = iv;
      in_data   = base + sent;
      out_ready = 1'b1;
      #1;
      if (expect_done && cyc == 0) begin
        check("sym_done_pulse", sym_done, 1);
        check("in_ready_after_last", in_ready, 1);
        check("out_valid_after_last", out_valid, 0);
      end
      if (expect_done && cyc == 1) check("sym_done_one_cycle", sym_done, 0);
      if (in_ready !== 1'b1) bad++;
      if (iv) begin
        if (mem_we !== (sent >= CPL)) bad++;
        if (sent >= CPL && mem_addra !== LOG2N'(sent - CPL)) bad++;
        if (sent == CPL) check("first_write_addr", mem_addra, 0);
        if (sent == CPL + N - 1) check("last_write_addr", mem_addra, N - 1);
        sent++;
      end else if (mem_we !== 1'b0) begin
        bad++;
      end
      cyc++;
    end
    check("fill_ctl_errors", bad, 0);
    check("fill_sample_count", sent, CPL + N);
  endtask

  // Drains until stop_after outputs are accepted. If stall_at >= 0,
  // out_ready is held low for 5 cycles while output number stall_at is
  // presented. in_valid stays high throughout to show it is ignored.
  task automatic drain_sym(input int base, input int stall_at, input int stop_after,
                           output int ncyc);
    int k          = 0;
    int cyc        = 0;
    int bad_ctl    = 0;
    int stall_left = 5;
    int stall_bad  = 0;
    bit rdy;
    while (k < stop_after && cyc < 400) begin
      @(negedge clk);
      rdy = 1'b1;
      if (out_valid && k == stall_at && stall_left > 0) rdy = 1'b0;
      in_valid  = 1'b1;
      in_data   = -1;
      out_ready = rdy;
      #1;
      if (in_ready !== 1'b0 || mem_we !== 1'b0 || sym_done !== 1'b0) bad_ctl++;
      if (!rdy) begin
        stall_left--;
        if (out_valid !== 1'b1 || out_index !== LOG2N'(br_tab[k]) ||
            mem_addrb !== LOG2N'(br_tab[k]) || rdata !== base + CPL + br_tab[k])
          stall_bad++;
      end
      if (out_valid && rdy) begin
        check($sformatf("out_index[%0d]", k), out_index, br_tab[k]);
        check($sformatf("out_data[%0d]", k), rdata, base + CPL + br_tab[k]);
        check($sformatf("out_last[%0d]", k), out_last, (k == N - 1));
        k++;
      end
      cyc++;
    end
    check("drain_ctl_errors", bad_ctl, 0);
    check("drain_output_count", k, stop_after);
    if (stall_at >= 0) begin
      check("stall_cycles", 5 - stall_left, 5);
      check("stall_hold_errors", stall_bad, 0);
    end
    ncyc = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nc;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_index", out_index, 0);
    check("rst_sym_done", sym_done, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_mem_we", mem_we, 0);
    @(negedge clk);
    rst_n = 1'b0;

    // Plain symbol, continuous flow.
    fill_sym(0, 1'b0, 1'b0);
    drain_sym(0, -1, N, nc);
    check("drain_cycles_stream", nc, N + 1);

    // Back-to-back symbol with a 5-cycle stall at the third output.
    fill_sym(100, 1'b0, 1'b1);
    drain_sym(100, 2, N, nc);
    check("drain_cycles_stall", nc, N + 1 + 5);

    // Gapped input during fill.
    fill_sym(200, 1'b1, 1'b1);
    drain_sym(200, -1, N, nc);
    check("drain_cycles_gapped", nc, N + 1);

    // Reset after 10 outputs, then a fresh symbol.
    fill_sym(300, 1'b0, 1'b1);
    drain_sym(300, -1, 10, nc);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_last", out_last, 0);
    @(negedge clk);
    #1;
    check("midrst_out_valid_hold", out_valid, 0);
    rst_n = 1'b0;
    fill_sym(400, 1'b0, 1'b0);
    drain_sym(400, -1, N, nc);
    check("drain_cycles_after_rst", nc, N + 1);

    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("final_sym_done", sym_done, 1);
    check("final_in_ready", in_ready, 1);
    check("final_out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_reorder_ctrl.md
Name: fft_reorder_ctrl

Overview:
- Sequencer for the single-port-write / registered-read complex sample buffer (N x Q real/imag, shared `we`) in the receiver chain.
- Fills the buffer with one OFDM symbol in natural order, then drains it in bit-reversed order, so FFT output reaches the demapper in natural frequency order.
- Owns all buffer control (`we`, `addra`, `addrb`) and the in/out valid-ready handshakes.
- Sample data travels straight through the buffer; this block carries no data bits.

Parameters:
- N, 64, symbol length / buffer depth (power of two).
- LOG2N, 6, address width; must equal log2(N).
- CP, 16, cyclic-prefix length; used only when CP_STRIP_EN is defined.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-high (despite the name).
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- out_valid  out  1  buffer read register holds a valid reordered sample.
- out_ready  in  1  downstream accepts the current sample.
- out_last  out  1  current output is the final sample of the symbol.
- out_index  out  LOG2N  natural-order index (0..N-1) of the current output sample.
- mem_we  out  1  buffer write enable.
- mem_addra  out  LOG2N  buffer write address.
- mem_addrb  out  LOG2N  buffer read address.
- sym_done  out  1  one-cycle pulse when the last sample of a symbol is accepted downstream.

Behaviour:
- Reset state and outputs:
  - state = FILL; wr_cnt = rd_cnt = 0; held read address = 0.
  - out_valid = 0, out_last = 0, out_index = 0, sym_done = 0.
  - Reset mid-symbol discards all progress; no partial drain.
- States:
  - FILL:
    - in_ready = 1.
    - A handshake (in_valid & in_ready) asserts mem_we = 1 combinationally, with mem_addra = wr_cnt; wr_cnt then increments.
    - The handshake that writes address N-1 moves the FSM to DRAIN at the same edge; wr_cnt wraps to 0.
  - DRAIN:
    - in_ready = 0, mem_we = 0.
    - issue = (rd_cnt_issued < N) & (!out_valid | out_ready).
    - When issue is true, mem_addrb = bitrev(rd_cnt) combinationally. At that edge the buffer captures the data, out_valid goes to 1, out_index <= bitrev(rd_cnt), the held address <= bitrev(rd_cnt), and rd_cnt increments.
    - When issue is false, mem_addrb = held address. The buffer re-reads the same location, so the data stays stable under a stall.
  - Transition DRAIN -> FILL: the edge where out_valid & out_ready & out_last. At that edge out_valid clears, sym_done pulses for 1 cycle, and rd_cnt clears.
- mem_addrb in FILL equals the held address and is don't-care. Buffer reads during FILL are ignored because out_valid = 0.
- out_valid is registered: the first output is valid 1 cycle after entering DRAIN. Zero-bubble streaming is required while out_ready = 1.
- out_last = out_valid & (sample is the N-th issued).
- No overlap between fill and drain, because the buffer has one shared we. Minimum period per symbol: N input cycles + N + 1 output cycles.
- bitrev: reverse all LOG2N bits (for N=64, index 1 -> 32, 3 -> 48).
- in_valid in DRAIN is ignored; no sample is lost, because in_ready = 0.

Optional Feature:
- Macro: CP_STRIP_EN.
- Defined:
  - Each symbol starts with a CP phase inside FILL, counted by cp_cnt 0..CP-1.
  - The first CP handshaken samples are accepted (in_ready = 1) but not written: mem_we = 0, wr_cnt unchanged.
  - The next N samples are written as above.
  - cp_cnt resets on rst_n and on the DRAIN -> FILL transition.
- Undefined: every FILL handshake is written; the CP parameter has no effect.

Test Plan:
1. Reset mid-DRAIN (assert rst_n after 10 outputs) -> out_valid = 0 next cycle, state FILL, in_ready = 1; the next 64 writes use addra 0..63.
2. Feed 64 samples with values 0..63, out_ready = 1 -> mem_addra 0..63 with mem_we = 1. Outputs appear in order 0, 32, 16, 48, 8, …, 63 on consecutive cycles with out_index matching. out_last and sym_done on the 64th output; in_ready = 1 the cycle after.
3. Stall: hold out_ready = 0 for 5 cycles at the 3rd output (index 16) -> out_valid stays 1, data and out_index stay 16, mem_addrb stays 16. Resume gives 48 next with no skip or duplicate.
4. in_valid toggled 1/0 during FILL -> exactly 64 writes, gaps cause no address advance. in_valid = 1 during DRAIN -> in_ready = 0, mem_we = 0.
5. Back-to-back symbols A then B -> B's first write occurs on the cycle after A's last output is accepted; B's output order is again bit-reversed.
6. With CP_STRIP_EN, CP = 16, feed 80 samples 0..79 -> samples 0..15 accepted with mem_we = 0; sample 16 written to addra 0; output stream is 16, 48, 32, … (bitrev order of 16..79).
